reg_file_sb: RTL and testbench

- Parametrised general-purpose register file for the datapath: DEPTH registers of WIDTH bits.
- One write port and two combinational read ports (A and B).
- Optional hardwired-zero R0 and optional write-to-read bypass.
- Per-register busy scoreboard for the control unit: set when an instruction targeting the register issues, cleared when its result is written back.

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_entry.sv | 35 +++
 rtl/reg_file_sb.sv | 106 ++++++++++
 tb/tb_reg_file_sb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the datapath register file
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);
    localparam int REG_ZERO      = 0;

    typedef logic [DEFAULT_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_entry.sv
// rtl/reg_entry.sv - single register with enable and asynchronous clear
module reg_entry
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with two read ports, write bypass and busy scoreboard
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter bit               ZERO_R0   = 1'b1,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic [DEPTH-1:0] busy_vec
);

    logic [WIDTH-1:0] reg_val [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] iss_sel;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // An address names real storage only if in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_R0 && (a == AW'(REG_ZERO)));
    endfunction

    always_comb begin
        wr_sel  = '0;
        iss_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i]  = wr_en    && addr_ok(wr_addr)    && (wr_addr    == AW'(i));
            iss_sel[i] = issue_en && addr_ok(issue_addr) && (issue_addr == AW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        if (ZERO_R0 && (g == REG_ZERO)) begin : g_zero
            assign reg_val[g] = '0;
        end else begin : g_entry
            reg_entry #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_entry (
                .clk(clk),
                .clr(clr),
                .en (wr_sel[g]),
                .d  (wr_data),
                .q  (reg_val[g])
            );
        end
    end

    // Issue is applied after writeback so a same-cycle set beats the clear.
    always_comb begin
        busy_d = (busy_q & ~wr_sel) | iss_sel;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_a = '0;
        busy_a    = 1'b0;
        if (addr_ok(rd_addr_a)) begin
            busy_a = busy_q[rd_addr_a];
            if (BYPASS && !clr && wr_en && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = reg_val[rd_addr_a];
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        busy_b    = 1'b0;
        if (addr_ok(rd_addr_b)) begin
            busy_b = busy_q[rd_addr_b];
            if (BYPASS && !clr && wr_en && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = reg_val[rd_addr_b];
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - bench for reg_file_sb across four parameter sets sharing one stimulus
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        wr_en;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    reg_addr_t   rd_addr_a;
    reg_addr_t   rd_addr_b;
    logic        issue_en;
    reg_addr_t   issue_addr;

    logic [31:0] rda [4];
    logic [31:0] rdb [4];
    logic        ba  [4];
    logic        bb  [4];
    logic [15:0] bv0, bv1, bv3;
    logic [11:0] bv2;
    logic [15:0] bvx [4];

    assign bvx[0] = bv0;
    assign bvx[1] = bv1;
    assign bvx[2] = {4'b0, bv2};
    assign bvx[3] = bv3;

    int          cdepth [4] = '{16, 16, 12, 16};
    bit          czero  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit          cbyp   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] crv    [4] = '{32'h0, 32'h0, 32'h0, 32'h0BADF00D};

    logic [31:0] mregs [4][64];
    logic        mbusy [4][64];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1'b1), .BYPASS(1'b1), .RESET_VAL(32'h0)) u_d0 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(ba[0]), .busy_b(bb[0]), .busy_vec(bv0));

    reg_file_sb #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1'b1), .BYPASS(1'b0), .RESET_VAL(32'h0)) u_d1 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(ba[1]), .busy_b(bb[1]), .busy_vec(bv1));

    reg_file_sb #(.WIDTH(32), .DEPTH(12), .ZERO_R0(1'b1), .BYPASS(1'b1), .RESET_VAL(32'h0)) u_d2 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(ba[2]), .busy_b(bb[2]), .busy_vec(bv2));

    reg_file_sb #(.WIDTH(32), .DEPTH(16), .ZERO_R0(1'b0), .BYPASS(1'b1), .RESET_VAL(32'h0BADF00D)) u_d3 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda[3]), .rd_addr_b(rd_addr_b), .rd_data_b(rdb[3]),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_a(ba[3]), .busy_b(bb[3]), .busy_vec(bv3));

    function automatic bit is_real(int k, logic [3:0] a);
        return (int'(a) < cdepth[k]) && !(czero[k] && a == 4'd0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [3:0] a);
        if (!is_real(k, a)) return 32'h0;
        if (cbyp[k] && !clr && wr_en && wr_addr == a) return wr_data;
        return mregs[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [3:0] a);
        return is_real(k, a) && mbusy[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) begin
                mregs[k][i] = crv[k];
                mbusy[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        if (clr) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (wr_en && is_real(k, wr_addr)) begin
                mregs[k][wr_addr] = wr_data;
                mbusy[k][wr_addr] = 1'b0;
            end
            if (issue_en && is_real(k, issue_addr)) begin
                mbusy[k][issue_addr] = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s d%0d rd_a", tag, k), rda[k], exp_rd(k, rd_addr_a));
            chk($sformatf("%s d%0d rd_b", tag, k), rdb[k], exp_rd(k, rd_addr_b));
            chk($sformatf("%s d%0d busy_a", tag, k), {31'b0, ba[k]}, {31'b0, exp_busy(k, rd_addr_a)});
            chk($sformatf("%s d%0d busy_b", tag, k), {31'b0, bb[k]}, {31'b0, exp_busy(k, rd_addr_b)});
            for (int i = 0; i < 16; i++) v[i] = exp_busy(k, 4'(i));
            chk($sformatf("%s d%0d busy_vec", tag, k), {16'b0, bvx[k]}, {16'b0, v});
        end
    endtask

    task automatic drive(logic we, logic [3:0] wa, logic [31:0] wd, logic [3:0] ra, logic [3:0] rb,
                         logic ie, logic [3:0] ia);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb;
        issue_en = ie; issue_addr = ia;
    endtask

    task automatic cycle(string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        ie;
        logic [3:0]  ia;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eba;
        logic        ebb;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 4'd5,  4'd9,  1'b0, 4'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd9,  32'h0000CAFE, 4'd5,  4'd9,  1'b0, 4'd0,  32'hDEADBEEF, 32'h0000CAFE, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'd0,  32'h0,        4'd5,  4'd9,  1'b0, 4'd0,  32'hDEADBEEF, 32'h0000CAFE, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd7,  32'hA5A5A5A5, 4'd7,  4'd7,  1'b0, 4'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'd0,  32'hFFFFFFFF, 4'd0,  4'd7,  1'b1, 4'd0,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0,  32'h0,        4'd0,  4'd0,  1'b0, 4'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'd0,  32'h0,        4'd4,  4'd4,  1'b1, 4'd4,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'd4,  32'h00000011, 4'd4,  4'd5,  1'b1, 4'd4,  32'h00000011, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'd4,  32'h00000022, 4'd4,  4'd4,  1'b0, 4'd0,  32'h00000022, 32'h00000022, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'd0,  32'h0,        4'd4,  4'd13, 1'b0, 4'd0,  32'h00000022, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'd13, 32'h00000055, 4'd13, 4'd5,  1'b1, 4'd13, 32'h00000055, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'd0,  32'h0,        4'd13, 4'd15, 1'b0, 4'd0,  32'h00000055, 32'h0,        1'b1, 1'b0};

        clr = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 4'd5, 4'd0, 1'b0, 4'd0);
        model_reset();
        #3;
        check_all("reset");
        chk("reset d3 rd_a resetval", rda[3], 32'h0BADF00D);
        chk("reset d0 rd_a", rda[0], 32'h0);
        #4;
        clr = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].ra, tbl[r].rb, tbl[r].ie, tbl[r].ia);
            #1;
            chk($sformatf("tbl%0d rd_a", r), rda[0], tbl[r].ea);
            chk($sformatf("tbl%0d rd_b", r), rdb[0], tbl[r].eb);
            chk($sformatf("tbl%0d busy_a", r), {31'b0, ba[0]}, {31'b0, tbl[r].eba});
            chk($sformatf("tbl%0d busy_b", r), {31'b0, bb[0]}, {31'b0, tbl[r].ebb});
            check_all($sformatf("tbl%0d", r));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Asynchronous clear mid-cycle, then writes/issues presented under clear.
        drive(1'b1, 4'd3, 32'h12345678, 4'd0, 4'd0, 1'b1, 4'd3);
        cycle("pre_clr");
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd4, 1'b0, 4'd0);
        #1;
        chk("pre_clr R3", rda[0], 32'h12345678);
        chk("pre_clr busy3", {31'b0, bv0[3]}, 32'h1);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        chk("clr async R3", rda[0], 32'h0);
        chk("clr async busy_vec", {16'b0, bv0}, 32'h0);
        check_all("clr_async");
        drive(1'b1, 4'd3, 32'h00000077, 4'd3, 4'd3, 1'b1, 4'd3);
        cycle("clr_held");
        clr = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, 1'b0, 4'd0);
        #1;
        chk("post_clr R3", rda[0], 32'h0);
        chk("post_clr d3 R3", rda[3], 32'h0BADF00D);
        cycle("post_clr");

        // Bypass versus no-bypass on the same write.
        drive(1'b1, 4'd7, 32'hA5A5A5A5, 4'd7, 4'd7, 1'b0, 4'd0);
        #1;
        chk("bypass d0", rda[0], 32'hA5A5A5A5);
        chk("nobypass d1 old", rda[1], 32'h0);
        cycle("bypass");
        drive(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, 1'b0, 4'd0);
        #1;
        chk("nobypass d1 after edge", rda[1], 32'hA5A5A5A5);

        // Out-of-range index 13 on the 12-deep instance.
        drive(1'b1, 4'd13, 32'h00000055, 4'd13, 4'd13, 1'b1, 4'd13);
        #1;
        chk("oor d2 bypass", rda[2], 32'h0);
        cycle("oor");
        drive(1'b0, 4'd0, 32'h0, 4'd13, 4'd11, 1'b0, 4'd0);
        #1;
        chk("oor d2 rd", rda[2], 32'h0);
        chk("oor d2 busy", {31'b0, ba[2]}, 32'h0);
        chk("oor d2 busy_vec", {20'b0, bv2}, 32'h0);
        cycle("oor_after");

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            cycle($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
